// File: rtl/amplitude_ramp_scaler_pkg.sv
// amplitude_ramp_scaler_pkg: shared FSM state encoding and sizing helpers.
package amplitude_ramp_scaler_pkg;

    typedef logic [0:0] state_t;
    localparam state_t STEADY = 1'b0;
    localparam state_t RAMP   = 1'b1;

    function automatic int clog2(int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int cnt_w(int hold);
        return clog2(hold) < 1 ? 1 : clog2(hold);
    endfunction

    function automatic int mid_code(int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/amplitude_shift_unit.sv
// amplitude_shift_unit: combinational power-of-two attenuation, toward zero or toward mid-code.
module amplitude_shift_unit
    import amplitude_ramp_scaler_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 2,
    parameter int CENTERED = 0
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  level_i,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [DATA_W:0] MID = (DATA_W + 1)'(mid_code(DATA_W));

    logic signed [DATA_W:0] d;
    logic signed [DATA_W:0] s;

    // One extra bit keeps the offset sample signed; mid + floor(d/2^n) always fits DATA_W.
    assign d      = $signed({1'b0, data_i}) - $signed(MID);
    assign s      = d >>> level_i;
    assign data_o = CENTERED != 0 ? DATA_W'(MID + $unsigned(s)) : data_i >> level_i;

endmodule

// File: rtl/amplitude_ramp_scaler.sv
// amplitude_ramp_scaler: click-free attenuator stepping one level every HOLD accepted samples.
module amplitude_ramp_scaler
    import amplitude_ramp_scaler_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 2,
    parameter int HOLD     = 4,
    parameter int CENTERED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              inValid,
    input  logic [SEL_W-1:0]  selector,
    output logic [DATA_W-1:0] dataOut,
    output logic              outValid,
    output logic [SEL_W-1:0]  currentLevel,
    output logic              ramping
);

    localparam int CW = cnt_w(HOLD);
    localparam logic [DATA_W-1:0] RST_DATA = CENTERED != 0 ? DATA_W'(mid_code(DATA_W)) : '0;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  lvl_q, lvl_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_cur;
    logic [DATA_W-1:0] data_q, scaled;
    logic              valid_q, step;

    amplitude_shift_unit #(
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W),
        .CENTERED(CENTERED)
    ) u_shift (
        .data_i (dataIn),
        .level_i(lvl_q),
        .data_o (scaled)
    );

    assign ramping      = selector != lvl_q;
    assign dataOut      = data_q;
    assign outValid     = valid_q;
    assign currentLevel = lvl_q;

    // A mismatch acts as RAMP immediately; the state register only lags by one cycle.
    always_comb begin
        cnt_cur = state_q == RAMP ? cnt_q : '0;
        step    = ramping && inValid && cnt_cur == CW'(HOLD - 1);
        lvl_d   = step ? (selector > lvl_q ? lvl_q + 1'b1 : lvl_q - 1'b1) : lvl_q;
        cnt_d   = !ramping ? '0 : step ? '0 : inValid ? cnt_cur + 1'b1 : cnt_cur;
        state_d = lvl_d == selector ? STEADY : RAMP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STEADY;
            lvl_q   <= '0;
            cnt_q   <= '0;
            data_q  <= RST_DATA;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            valid_q <= inValid;
            if (inValid) data_q <= scaled;
        end
    end

endmodule
